// File: rtl/updown_counter_param_if.sv
// Control, limit and status bundle for updown_counter_param.
// The counter sits on the slave side; the master drives the controls and observes the status.
interface updown_counter_param_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              en;
  logic              load;
  logic              updown;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  lo_lim;
  logic [WIDTH-1:0]  hi_lim;
  logic              sat_mode;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_min;
  logic              ovf;
  logic              unf;
  logic              cfg_err;

  modport master (
    output en, load, updown, step, data, lo_lim, hi_lim, sat_mode,
    input  count, at_max, at_min, ovf, unf, cfg_err
  );

  modport slave (
    input  en, load, updown, step, data, lo_lim, hi_lim, sat_mode,
    output count, at_max, at_min, ovf, unf, cfg_err
  );
endinterface

// File: rtl/updown_counter_param.sv
// Up/down counter with variable step, runtime inclusive limits, wrap or saturate at the
// limits, and registered one-cycle overflow/underflow pulses.
module updown_counter_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  updown_counter_param_if.slave bus
);
  logic [WIDTH-1:0] count_r;
  logic             ovf_r;
  logic             unf_r;

  logic             cfg_err_s;
  logic [WIDTH:0]   step_ext_s;
  logic [WIDTH:0]   lo_ext_s;
  logic [WIDTH:0]   hi_ext_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] clamp_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;

  assign cfg_err_s  = (bus.lo_lim > bus.hi_lim);
  assign step_ext_s = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
  assign lo_ext_s   = {1'b0, bus.lo_lim};
  assign hi_ext_s   = {1'b0, bus.hi_lim};
  // One extra bit keeps the carry and the borrow visible instead of wrapping silently.
  assign sum_s      = {1'b0, count_r} + step_ext_s;
  assign diff_s     = {1'b0, count_r} - step_ext_s;

  // Clamp the load value into the current limits.
  always_comb begin
    clamp_s = bus.data;
    if (bus.data < bus.lo_lim) begin
      clamp_s = bus.lo_lim;
    end else if (bus.data > bus.hi_lim) begin
      clamp_s = bus.hi_lim;
    end else begin
      clamp_s = bus.data;
    end
  end

  // Next count and event selection: load beats count, count beats hold.
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    unf_nxt_s   = 1'b0;
    if (bus.load) begin
      if (cfg_err_s) begin
        count_nxt_s = bus.data;
      end else begin
        count_nxt_s = clamp_s;
      end
    end else if (bus.en && !cfg_err_s && (bus.step != {STEP_W{1'b0}})) begin
      if (bus.updown) begin
        if (sum_s <= hi_ext_s) begin
          count_nxt_s = sum_s[WIDTH-1:0];
        end else begin
          ovf_nxt_s   = 1'b1;
          count_nxt_s = bus.sat_mode ? bus.hi_lim : bus.lo_lim;
        end
      end else begin
        // Signed compare: a borrow past zero is negative and therefore below any limit.
        if ($signed(diff_s) >= $signed(lo_ext_s)) begin
          count_nxt_s = diff_s[WIDTH-1:0];
        end else begin
          unf_nxt_s   = 1'b1;
          count_nxt_s = bus.sat_mode ? bus.lo_lim : bus.hi_lim;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and event registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  assign bus.count   = count_r;
  assign bus.ovf     = ovf_r;
  assign bus.unf     = unf_r;
  assign bus.cfg_err = cfg_err_s;
  assign bus.at_max  = (count_r == bus.hi_lim) && !cfg_err_s;
  assign bus.at_min  = (count_r == bus.lo_lim) && !cfg_err_s;
endmodule

// File: tb/tb_updown_counter_param.sv
// Directed-vector bench for updown_counter_param: the driver queues hand-computed expectations,
// and an independent monitor pops and compares them half a cycle after each edge.
module tb_updown_counter_param;
  logic clk;
  logic rst;

  updown_counter_param_if #(.WIDTH(8), .STEP_W(4)) bus ();

  updown_counter_param #(.WIDTH(8), .STEP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [7:0] count;
    logic       ovf;
    logic       unf;
    logic       at_max;
    logic       at_min;
    logic       cfg_err;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   next_id     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [7:0] c, input logic o, input logic u,
                          input logic mx, input logic mn, input logic er);
    exp_t e;
    e.id = next_id; e.count = c; e.ovf = o; e.unf = u;
    e.at_max = mx; e.at_min = mn; e.cfg_err = er;
    next_id++;
    sb.push_back(e);
  endtask

  // One clock of stimulus followed by the expected state after that edge.
  task automatic cyc(input logic en_v, input logic ld_v, input logic up_v, input logic [3:0] st,
                     input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi, input logic sat,
                     input logic [7:0] ec, input logic eo, input logic eu,
                     input logic emx, input logic emn, input logic eer);
    @(negedge clk); #1;
    bus.en = en_v; bus.load = ld_v; bus.updown = up_v; bus.step = st;
    bus.data = d; bus.lo_lim = lo; bus.hi_lim = hi; bus.sat_mode = sat;
    @(posedge clk);
    push_exp(ec, eo, eu, emx, emn, eer);
  endtask

  // Monitor: compares every queued expectation against the outputs at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (bus.count !== e.count || bus.ovf !== e.ovf || bus.unf !== e.unf ||
            bus.at_max !== e.at_max || bus.at_min !== e.at_min || bus.cfg_err !== e.cfg_err) begin
          miscompares++;
          $display("FAIL vec%0d: got count=%0d ovf=%b unf=%b max=%b min=%b err=%b, want count=%0d ovf=%b unf=%b max=%b min=%b err=%b",
                   e.id, bus.count, bus.ovf, bus.unf, bus.at_max, bus.at_min, bus.cfg_err,
                   e.count, e.ovf, e.unf, e.at_max, e.at_min, e.cfg_err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.load = 1'b0; bus.updown = 1'b1; bus.step = 4'd0;
    bus.data = 8'd0; bus.lo_lim = 8'd0; bus.hi_lim = 8'd255; bus.sat_mode = 1'b0;
    #1;
    push_exp(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Mid-count asynchronous reset at 0x37.
    cyc(1'b0, 1'b1, 1'b1, 4'd1, 8'h36, 8'd0, 8'd255, 1'b0,  8'h36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 8'd0, 8'd255, 1'b0,  8'h37, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    bus.en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    push_exp(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;

    // Wrap up within [10,20] by 3.
    cyc(1'b1, 1'b1, 1'b1, 4'd3, 8'd18, 8'd10, 8'd20, 1'b0,  8'd18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd3, 8'd0,  8'd10, 8'd20, 1'b0,  8'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd3, 8'd0,  8'd10, 8'd20, 1'b0,  8'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturating down by 4: unf repeats while pinned at lo.
    cyc(1'b0, 1'b1, 1'b0, 4'd4, 8'd12, 8'd10, 8'd20, 1'b1,  8'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd4, 8'd0,  8'd10, 8'd20, 1'b1,  8'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd4, 8'd0,  8'd10, 8'd20, 1'b1,  8'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Load clamps and wins over en; bad limits load raw and block counting.
    cyc(1'b1, 1'b1, 1'b1, 4'd3, 8'd250, 8'd0, 8'd200, 1'b0, 8'd200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 4'd3, 8'd250, 8'd5, 8'd3,   1'b0, 8'd250, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 4'd3, 8'd0,   8'd5, 8'd3,   1'b0, 8'd250, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full range: 250 + 15 overflows to 0, not 9.
    cyc(1'b0, 1'b1, 1'b1, 4'd15, 8'd250, 8'd0, 8'd255, 1'b0, 8'd250, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd15, 8'd0,   8'd0, 8'd255, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Hold: zero step, then en low.
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'd100, 8'd0, 8'd255, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 1'b1, 4'd0, 8'd0, 8'd0, 8'd255, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b0, 4'd5, 8'd0, 8'd0, 8'd255, 1'b0, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // hi drops below count: the next up step is an overflow and wraps to lo.
    cyc(1'b1, 1'b0, 1'b1, 4'd1, 8'd0, 8'd5, 8'd50, 1'b0,  8'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Degenerate range lo == hi == 30.
    cyc(1'b0, 1'b1, 1'b1, 4'd2, 8'd77, 8'd30, 8'd30, 1'b0, 8'd30, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd2, 8'd0,  8'd30, 8'd30, 1'b0, 8'd30, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd1, 8'd0,  8'd30, 8'd30, 1'b1, 8'd30, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Down from above hi and up from below lo both move arithmetically.
    cyc(1'b0, 1'b1, 1'b1, 4'd5, 8'd200, 8'd0,  8'd255, 1'b0, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd5, 8'd0,   8'd0,  8'd100, 1'b0, 8'd195, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 4'd5, 8'd10,  8'd0,  8'd255, 1'b0, 8'd10,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 4'd5, 8'd0,   8'd50, 8'd100, 1'b0, 8'd15,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
